pulse_stretcher: RTL and testbench

- Per-channel converter from single-cycle trigger pulses (e.g. oneshot button triggers, second ticks, alarm events) back to a held level of fixed, parameterised length.
- Drives human-visible outputs: LED blink on key press, buzzer beep, display flash.
- Sits downstream of the button oneshot and timekeeping logic, upstream of LED and buzzer pins.
- Also emits a one-cycle `done` pulse per channel when its window closes, so control FSMs can sequence on it.

---
 rtl/pulse_stretcher_pkg.sv | 19 +
 rtl/pulse_stretcher_ch.sv | 66 ++++++
 rtl/pulse_stretcher.sv | 33 +++
 tb/tb_pulse_stretcher.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher: channel state encoding,
// counter width helper and default stretch lengths for LED/buzzer channels.
package pulse_stretcher_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ch_state_e;

  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned STRETCH_LED_100MS = CLK_HZ / 10;
  localparam int unsigned STRETCH_BEEP_50MS = CLK_HZ / 20;

  // Down-counter width for a window of n cycles; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_stretcher_ch.sv
// Single stretcher channel: holds level high for STRETCH cycles per trigger and
// pulses done for one cycle when the window closes.
module pulse_stretch_ch
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned STRETCH   = 1000,
  parameter bit          RETRIGGER = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic level,
  output logic busy,
  output logic done
);

  localparam int unsigned      CNT_W  = cnt_width(STRETCH);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH - 1);

  ch_state_e        r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_done, w_done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (trig) begin
          w_state_next = ST_ACTIVE;
          w_cnt_next   = RELOAD;
        end
      end
      ST_ACTIVE: begin
        // A reload wins over expiry, so a trigger on the last cycle extends the window.
        if (RETRIGGER && trig) begin
          w_cnt_next = RELOAD;
        end else if (r_cnt == '0) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign level = (r_state == ST_ACTIVE);
  assign busy  = level;
  assign done  = r_done;

endmodule

// File: rtl/pulse_stretcher.sv
// WIDTH independent pulse stretcher channels sharing only clock and reset.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned STRETCH   = 1000,
  parameter bit          RETRIGGER = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] trig,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] done
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      pulse_stretch_ch #(
        .STRETCH  (STRETCH),
        .RETRIGGER(RETRIGGER)
      ) u_ch (
        .clk  (clk),
        .rst_n(rst_n),
        .trig (trig[gi]),
        .level(level[gi]),
        .busy (busy[gi]),
        .done (done[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher over four configurations, with a window-based
// expectation model feeding a per-cycle scoreboard.
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0] a_trig, a_level, a_busy, a_done;
  logic       b_trig, b_level, b_busy, b_done;
  logic       c_trig, c_level, c_busy, c_done;
  logic       d_trig, d_level, d_busy, d_done;

  pulse_stretcher #(.WIDTH(2), .STRETCH(4), .RETRIGGER(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .trig(a_trig), .level(a_level), .busy(a_busy), .done(a_done));
  pulse_stretcher #(.WIDTH(1), .STRETCH(4), .RETRIGGER(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .trig(b_trig), .level(b_level), .busy(b_busy), .done(b_done));
  pulse_stretcher #(.WIDTH(1), .STRETCH(1), .RETRIGGER(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .trig(c_trig), .level(c_level), .busy(c_busy), .done(c_done));
  pulse_stretcher #(.WIDTH(1), .STRETCH(1), .RETRIGGER(1'b0)) u_d (
    .clk(clk), .rst_n(rst_n), .trig(d_trig), .level(d_level), .busy(d_busy), .done(d_done));

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] lvl;
    logic [4:0] dn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Channels: 0,1 = u_a (S=4,R=1), 2 = u_b (S=4,R=0), 3 = u_c (S=1,R=1), 4 = u_d (S=1,R=0)
  int st[5] = '{4, 4, 4, 1, 1};
  bit rt[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  int ws[5];
  int we[5];

  task automatic check(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: got %b want %b", tag, cyc, obs, exp);
  endtask

  function automatic logic in_win(input int k, input int c);
    return (c >= ws[k]) && (c <= we[k]);
  endfunction

  function automatic logic [2:0] get_obs(input int k);
    case (k)
      0:       return {a_level[0], a_busy[0], a_done[0]};
      1:       return {a_level[1], a_busy[1], a_done[1]};
      2:       return {b_level, b_busy, b_done};
      3:       return {c_level, c_busy, c_done};
      4:       return {d_level, d_busy, d_done};
      default: return 3'b000;
    endcase
  endfunction

  initial begin
    exp_t     e_pop;
    exp_t     e_push;
    bit [4:0] tv;
    logic     cur;
    logic     nx;

    // Reset held with all triggers high: everything must stay low.
    a_trig = 2'b11; b_trig = 1'b1; c_trig = 1'b1; d_trig = 1'b1;
    rst_n  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_a", -1, {2'b00, a_level, a_busy, a_done}, 8'h00);
      check("rst_bcd", -1, {get_obs(2), get_obs(3), get_obs(4)} , 8'h00);
    end
    @(negedge clk);
    a_trig = 2'b00; b_trig = 1'b0; c_trig = 1'b0; d_trig = 1'b0;
    rst_n  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_a", -1, {2'b00, a_level, a_busy, a_done}, 8'h00);
      check("idle_bcd", -1, {get_obs(2), get_obs(3), get_obs(4)}, 8'h00);
    end

    for (int k = 0; k < 5; k++) begin
      ws[k] = -100;
      we[k] = -101;
    end

    // Main timeline: trig driven in cycle n is sampled at the following edge.
    for (int n = 0; n <= 45; n++) begin
      @(negedge clk);
      if (n > 0) begin
        e_pop = sb.pop_front();
        for (int k = 0; k < 5; k++)
          check($sformatf("ch%0d", k), e_pop.cyc, {5'b0, get_obs(k)},
                {5'b0, e_pop.lvl[k], e_pop.lvl[k], e_pop.dn[k]});
      end
      if (n < 45) begin
        tv[0] = (n == 10 || n == 13);
        tv[1] = (n == 30 || n == 34);
        tv[2] = (n == 10 || n == 13 || n == 14 || n == 15);
        tv[3] = (n >= 5 && n <= 7);
        tv[4] = (n >= 5 && n <= 7);
        a_trig = {tv[1], tv[0]};
        b_trig = tv[2];
        c_trig = tv[3];
        d_trig = tv[4];
        e_push.cyc = n + 1;
        for (int k = 0; k < 5; k++) begin
          cur = in_win(k, n);
          if (tv[k] && (rt[k] || !cur)) begin
            if (!cur) ws[k] = n + 1;
            we[k] = n + st[k];
          end
          nx = in_win(k, n + 1);
          e_push.lvl[k] = nx;
          e_push.dn[k]  = cur && !nx;
        end
        sb.push_back(e_push);
      end
    end

    // Independent channels, then a reset mid-window must abort without done.
    for (int n = 0; n <= 3; n++) begin
      @(negedge clk);
      if (n == 3) begin
        check("abort_pre", n, {6'b0, a_level}, 8'h03);
        a_trig = 2'b00;
        rst_n  = 1'b0;
        #1;
        check("abort_now", n, {2'b00, a_level, a_busy, a_done}, 8'h00);
      end else begin
        a_trig = (n == 0) ? 2'b01 : (n == 2) ? 2'b10 : 2'b00;
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("abort_post", n, {2'b00, a_level, a_busy, a_done}, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
